// File: rtl/calc_pkg.sv
// Shared types and constants for the calculator display path.
package calc_pkg;

    localparam int CALC_WIDTH  = 22;
    localparam int CALC_DIGITS = 6;

    localparam logic [3:0] BCD_BLANK = 4'hF;
    localparam logic [3:0] BCD_ERR   = 4'hE;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        FINISH = 2'd2
    } conv_state_t;

    // Digit count clamped into 1..CALC_DIGITS.
    function automatic logic [2:0] sanitize_len(input logic [2:0] len);
        if (len == 3'd0)
            return 3'd1;
        else if (len > 3'(CALC_DIGITS))
            return 3'(CALC_DIGITS);
        else
            return len;
    endfunction

endpackage

// File: rtl/bcd_add3.sv
// Double-dabble digit correction: adds 3 to a BCD digit of 5 or more.
module bcd_add3 (
    input  logic [3:0] value,
    output logic [3:0] adjusted
);

    assign adjusted = (value >= 4'd5) ? value + 4'd3 : value;

endmodule

// File: rtl/bcd_convert_seq.sv
// Sequential signed binary-to-BCD converter (shift-add-3) with start/busy/done handshake.
// Optional leading-zero blanking is enabled by defining BCD_BLANK_EN.
//
//   state  | meaning
//   IDLE   | waiting for start; outputs hold last result
//   SHIFT  | one add-3/shift step per cycle, 22 cycles
//   FINISH | format digits, latch sign/ovf, pulse done
module bcd_convert_seq
    import calc_pkg::*;
(
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         start,
    input  logic [CALC_WIDTH-1:0]        binary_num,
    input  logic [2:0]                   length,
    output logic                         busy,
    output logic                         done,
    output logic [4*CALC_DIGITS-1:0]     digits,
    output logic                         sign,
    output logic                         ovf
);

    conv_state_t             state;
    logic [4:0]              cnt;
    logic [CALC_WIDTH-1:0]   mag;
    logic [27:0]             acc;
    logic [27:0]             acc_adj;
    logic                    sign_q;
    logic [2:0]              len_q;
    logic                    ovf_next;
    logic [4*CALC_DIGITS-1:0] digits_next;

    // Seventh digit exists only to detect magnitudes above 999999.
    for (genvar g = 0; g < 7; g++) begin : g_add3
        bcd_add3 u_add3 (
            .value    (acc[4*g +: 4]),
            .adjusted (acc_adj[4*g +: 4])
        );
    end

    assign ovf_next = (acc[27:24] != 4'd0);

    always_comb begin
        digits_next = '0;
        for (int i = 0; i < CALC_DIGITS; i++) begin
            if (ovf_next) begin
                digits_next[4*i +: 4] = BCD_ERR;
            end else begin
                digits_next[4*i +: 4] = acc[4*i +: 4];
`ifdef BCD_BLANK_EN
                if (i != 0 && 3'(i) >= len_q)
                    digits_next[4*i +: 4] = BCD_BLANK;
`endif
            end
        end
    end

`ifndef BCD_BLANK_EN
    logic unused_len;
    assign unused_len = ^len_q;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            cnt    <= '0;
            mag    <= '0;
            acc    <= '0;
            sign_q <= 1'b0;
            len_q  <= 3'd1;
            busy   <= 1'b0;
            done   <= 1'b0;
            digits <= '0;
            sign   <= 1'b0;
            ovf    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        sign_q <= binary_num[CALC_WIDTH-1];
                        // Negating -2^21 wraps to 2^21, which is the correct unsigned magnitude.
                        mag    <= binary_num[CALC_WIDTH-1] ? (~binary_num + 1'b1) : binary_num;
                        len_q  <= sanitize_len(length);
                        acc    <= '0;
                        cnt    <= 5'(CALC_WIDTH);
                        busy   <= 1'b1;
                        state  <= SHIFT;
                    end
                end
                SHIFT: begin
                    acc <= {acc_adj[26:0], mag[CALC_WIDTH-1]};
                    mag <= {mag[CALC_WIDTH-2:0], 1'b0};
                    cnt <= cnt - 5'd1;
                    if (cnt == 5'd1)
                        state <= FINISH;
                end
                FINISH: begin
                    ovf    <= ovf_next;
                    digits <= digits_next;
                    sign   <= sign_q;
                    done   <= 1'b1;
                    busy   <= 1'b0;
                    state  <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
